if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the RISC-V pipeline: owns the program counter, issues word fetches to instruction memory over a req/ready handshake, and delivers {pc, instruction, opcode} through the IF/ID register to the control decoder. Handles branch/jump redirects, squashes stale fetches, and absorbs downstream stalls with a one-entry skid buffer so that no fetched instruction is ever lost or duplicated.

## Interface
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address, word-aligned (bits[1:0]=0)
- imem_ready  in  1  memory accepts request and returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_req && imem_ready
- redirect_valid  in  1  branch/jump taken, from EX
- redirect_pc  in  XLEN  redirect target; bits[1:0] ignored
- stall  in  1  ID cannot accept; IF/ID register holds
- id_valid  out  1  IF/ID register holds a live instruction
- id_pc  out  XLEN  pc of id_instr
- id_instr  out  32  instruction word
- id_opcode  out  7  id_instr[6:0], feeds control decoder

## Operation
- States: IDLE (reset), FETCH, KILL.
- IDLE: imem_req=0; unconditionally -> FETCH next cycle.
- FETCH: imem_req = !skid_valid; imem_addr = addr_q. On req&&ready: addr_q <= addr_q+4 (mod 2^32); data goes to IF/ID if !stall, else to skid.
- Handshake: once imem_req is high with ready low, req and addr stay stable until ready (stall never withdraws a request).
- IF/ID update when !stall: takes skid if skid_valid (skid clears); else takes memory data if accepted this cycle; else id_valid<=0 (bubble). When stall: id_* hold.
- Skid full => imem_req=0 until stall drops.
- Redirect (highest priority, any state): id_valid<=0, skid_valid<=0, target_q<=redirect_pc&~3.
  - If request accepted same cycle or no request outstanding: data discarded, addr_q<=target, stay/enter FETCH; next cycle requests target.
  - If request outstanding (req&&!ready): -> KILL.
- KILL: imem_req=1, imem_addr = held old addr; on ready data discarded, addr_q<=target_q, -> FETCH. Redirect in KILL updates target_q only.
- Redirect wins over stall: IF/ID is flushed even when stall=1.
- Reset values: state IDLE, addr_q=RESET_PC, imem_req=0, id_valid=0, id_pc=0, id_instr=32'h0000_0013 (NOP), id_opcode=7'h13, skid empty.
- rst asserted mid-request: request abandoned immediately; memory must tolerate req dropping.

## Timing
- imem_req/imem_addr combinational from registered state only (no path from ready/stall/redirect to req/addr).
- Fetch latency: data accepted in cycle N appears on id_* in cycle N+1.
- Throughput: 1 instr/cycle with ready tied high and no stall.
- First request: first cycle after rst deasserts is IDLE; req=1 at RESET_PC the following cycle.
- Redirect penalty with ready=1: redirect in cycle N, target requested N+1, on id_* N+2.

## Structure
- Shared package riscv_pkg: NOP constant 32'h0000_0013, opcode constants (ARITHMETIC, ARI_IMM, BRANCH, MEMLOAD, MEMSAVE, AUIPC, JAL, JALR), fetch state enum {IDLE, FETCH, KILL}.
- Sub-module fetch_skid: one-entry {pc, instr} buffer with load/drain/flush.

## Test plan
- Reset, ready=1, no stall -> id_pc 0,4,8,12 on consecutive cycles starting 3 cycles after rst drop; id_instr matches memory.
- ready low 3 cycles on addr 0x8 with stall toggling -> imem_addr held at 0x8, req held high, single delivery of 0x8.
- stall=1 for 4 cycles during streaming -> id_* frozen, one word captured in skid, req low; on release next pc delivered in order, no gap or duplicate.
- redirect_valid to 0x103 with ready=1 -> next req addr 0x100; id_valid=0 one cycle; 0x100 on id_* two cycles later.
- redirect to 0x200 while req at 0x40 stalled by ready=0, then redirect to 0x300 in KILL -> 0x40 data discarded, next fetch 0x300, 0x200 never fetched.
- pc at 0xFFFF_FFFC -> next fetch 0x0000_0000; rst asserted mid-fetch -> req=0, id_valid=0, id_instr=NOP immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: NOP encoding, major opcodes and fetch FSM states.
package riscv_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [6:0] OPC_ARITHMETIC = 7'b011_0011;
    localparam logic [6:0] OPC_ARI_IMM    = 7'b001_0011;
    localparam logic [6:0] OPC_BRANCH     = 7'b110_0011;
    localparam logic [6:0] OPC_MEMLOAD    = 7'b000_0011;
    localparam logic [6:0] OPC_MEMSAVE    = 7'b010_0011;
    localparam logic [6:0] OPC_AUIPC      = 7'b001_0111;
    localparam logic [6:0] OPC_JAL        = 7'b110_1111;
    localparam logic [6:0] OPC_JALR       = 7'b110_0111;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StKill
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry {pc, instr} holding buffer that catches a fetched word while ID is stalled.
module fetch_skid
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            drain_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;

    // Flush beats load beats drain; payload only changes on load.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem req/ready handshake, redirects and IF/ID register.
module if_stage
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e state_q, state_d;

    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [31:0]     id_instr_q, id_instr_d;

    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic            skid_load, skid_drain, skid_flush;

    logic            accept;
    logic            outstanding;
    logic [XLEN-1:0] redirect_tgt;

    assign accept       = imem_req && imem_ready;
    assign outstanding  = imem_req && !imem_ready;
    assign redirect_tgt = redirect_pc & ALIGN_MASK;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: KILL is only entered when a redirect hits an unanswered request.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: if (redirect_valid && outstanding) state_d = StKill;
            StKill:  if (imem_ready) state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: depend on registered state only, never on ready/stall/redirect.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = addr_q;
        unique case (state_q)
            StIdle:  imem_req = 1'b0;
            StFetch: imem_req = !skid_valid;
            StKill:  imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

    // Datapath next state: PC advance, redirect targets, IF/ID and skid steering.
    always_comb begin
        addr_d     = addr_q;
        target_d   = target_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_flush = 1'b0;

        if (redirect_valid) begin
            // Flush wins over stall; a still-pending request keeps its address until answered.
            id_valid_d = 1'b0;
            skid_flush = 1'b1;
            target_d   = redirect_tgt;
            if (!outstanding) begin
                addr_d = redirect_tgt;
            end
        end else if (state_q == StKill) begin
            // Returning word belongs to the wrong path and is dropped.
            id_valid_d = 1'b0;
            if (imem_ready) begin
                addr_d = target_q;
            end
        end else begin
            if (accept) begin
                addr_d = addr_q + XLEN'(4);
            end
            if (!stall) begin
                if (skid_valid) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = skid_pc;
                    id_instr_d = skid_instr;
                    skid_drain = 1'b1;
                end else if (accept) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = addr_q;
                    id_instr_d = imem_rdata;
                end else begin
                    id_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_load = 1'b1;
            end
        end
    end

    // Datapath registers: PC, pending redirect target and IF/ID register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= RESET_PC & ALIGN_MASK;
            target_q   <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= NOP;
        end else begin
            addr_q     <= addr_d;
            target_q   <= target_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    fetch_skid #(
        .XLEN (XLEN)
    ) u_skid (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .flush_i (skid_flush),
        .pc_i    (addr_q),
        .instr_i (imem_rdata),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_instr  = id_instr_q;
    assign id_opcode = id_instr_q[6:0];

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// checked against a program-order model of the delivered instruction stream.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model state
    logic [31:0] exp_pc;
    logic        want_bubble;
    logic        prev_wait;
    logic [31:0] prev_addr;
    logic        seen_200;
    int          n_deliv;

    always #5 clk = ~clk;

    if_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A3C_0F17;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Program-order model: every word ID consumes must be the next pc in sequence,
    // a redirect restarts the sequence at the aligned target and flushes IF/ID.
    task automatic model_step();
        logic [31:0] w;
        if (rst) begin
            exp_pc      = 32'h0;
            want_bubble = 1'b0;
            prev_wait   = 1'b0;
            prev_addr   = 32'h0;
        end else begin
            if (want_bubble) check_eq("flush_bubble", {31'b0, id_valid}, 32'd0);
            if (prev_wait) begin
                check_eq("hold_req", {31'b0, imem_req}, 32'd1);
                check_eq("hold_addr", imem_addr, prev_addr);
            end
            if (imem_req) check_eq("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
            if (id_valid && !stall) begin
                w = mem_word(exp_pc);
                check_eq("seq_pc", id_pc, exp_pc);
                check_eq("seq_instr", id_instr, w);
                check_eq("seq_opcode", {25'b0, id_opcode}, {25'b0, w[6:0]});
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
            end
            if (imem_req && imem_ready && imem_addr == 32'h200) seen_200 = 1'b1;
            want_bubble = redirect_valid;
            if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
            prev_wait = imem_req && !imem_ready;
            prev_addr = imem_addr;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        imem_ready     = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        seen_200       = 1'b0;
        n_deliv        = 0;
        exp_pc         = 32'h0;
        want_bubble    = 1'b0;
        prev_wait      = 1'b0;
        prev_addr      = 32'h0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req", {31'b0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'b0, id_valid}, 32'd0);
        check_eq("rst_pc", id_pc, 32'h0);
        check_eq("rst_instr", id_instr, 32'h0000_0013);
        check_eq("rst_opcode", {25'b0, id_opcode}, 32'h13);

        // Start-up: IDLE cycle, then stream 0,4,8,12 back to back
        rst = 1'b0;
        check_eq("idle_req", {31'b0, imem_req}, 32'd0);
        tick();
        check_eq("first_req", {31'b0, imem_req}, 32'd1);
        check_eq("first_addr", imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("stream_valid", {31'b0, id_valid}, 32'd1);
            check_eq("stream_pc", id_pc, 32'(i * 4));
        end

        // Redirect to an unaligned target with ready high
        do_redirect(32'h0000_0103);
        check_eq("redir_addr", imem_addr, 32'h100);
        check_eq("redir_req", {31'b0, imem_req}, 32'd1);
        check_eq("redir_bubble", {31'b0, id_valid}, 32'd0);
        tick();
        check_eq("redir_valid", {31'b0, id_valid}, 32'd1);
        check_eq("redir_pc", id_pc, 32'h100);

        // ready low for 3 cycles on 0x8 while stall toggles
        do_redirect(32'h8);
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'b0;
            stall      = (i % 2) == 0;
            check_eq("wait_req", {31'b0, imem_req}, 32'd1);
            check_eq("wait_addr", imem_addr, 32'h8);
            tick();
        end
        imem_ready = 1'b1;
        stall      = 1'b0;
        check_eq("wait_addr_end", imem_addr, 32'h8);
        tick();
        check_eq("wait_deliv", id_pc, 32'h8);
        check_eq("wait_deliv_v", {31'b0, id_valid}, 32'd1);

        // Four stall cycles while streaming: skid catches one word, req drops
        do_redirect(32'h500);
        tick();
        tick();
        check_eq("pre_stall_pc", id_pc, 32'h504);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("stall_pc", id_pc, 32'h504);
            check_eq("stall_valid", {31'b0, id_valid}, 32'd1);
            check_eq("stall_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        check_eq("skid_pc", id_pc, 32'h508);
        check_eq("skid_next_addr", imem_addr, 32'h50C);
        tick();
        check_eq("after_skid_pc", id_pc, 32'h50C);
        check_eq("after_skid_v", {31'b0, id_valid}, 32'd1);

        // Redirect while a request is pending, then retarget inside KILL
        do_redirect(32'h40);
        imem_ready = 1'b0;
        seen_200   = 1'b0;
        tick();
        check_eq("pend_addr", imem_addr, 32'h40);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        check_eq("kill_req", {31'b0, imem_req}, 32'd1);
        check_eq("kill_addr", imem_addr, 32'h40);
        redirect_pc = 32'h300;
        tick();
        check_eq("kill2_addr", imem_addr, 32'h40);
        redirect_valid = 1'b0;
        imem_ready     = 1'b1;
        tick();
        check_eq("kill_exit_addr", imem_addr, 32'h300);
        check_eq("kill_exit_v", {31'b0, id_valid}, 32'd0);
        tick();
        check_eq("kill_deliv", id_pc, 32'h300);
        check_eq("no_fetch_200", {31'b0, seen_200}, 32'd0);

        // Address wrap at the top of the address space
        do_redirect(32'hFFFF_FFFC);
        check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_addr1", imem_addr, 32'h0);
        check_eq("wrap_pc0", id_pc, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_pc1", id_pc, 32'h0);

        // Reset in the middle of a pending fetch
        imem_ready = 1'b0;
        tick();
        check_eq("mid_req", {31'b0, imem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_req", {31'b0, imem_req}, 32'd0);
        check_eq("mid_rst_valid", {31'b0, id_valid}, 32'd0);
        check_eq("mid_rst_instr", id_instr, 32'h0000_0013);
        check_eq("mid_rst_pc", id_pc, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Randomized traffic
        n_deliv = 0;
        for (int i = 0; i < 1500; i++) begin
            imem_ready     = ($urandom_range(0, 9) < 7);
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        check_eq("progress", {31'b0, (n_deliv > 200)}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
